// File: rtl/gpio_pkg.sv
// Shared definitions for the Wishbone GPIO responder: bus widths, register
// indices and a byte-lane helper.
package gpio_pkg;

  localparam int WB_DW = 32;
  localparam int WB_AW = 5;

  typedef enum logic [2:0] {
    GPIO_DATA_IN  = 3'd0,
    GPIO_DATA_OUT = 3'd1,
    GPIO_DIR      = 3'd2,
    GPIO_IRQ_EN   = 3'd3,
    GPIO_IRQ_STAT = 3'd4,
    GPIO_EDGE_POL = 3'd5,
    GPIO_RSVD6    = 3'd6,
    GPIO_RSVD7    = 3'd7
  } gpio_reg_e;

  // Expands a byte-lane select into a bit mask over the data word.
  function automatic logic [WB_DW-1:0] lane_mask(input logic [WB_DW/8-1:0] sel);
    logic [WB_DW-1:0] m;
    m = '0;
    for (int b = 0; b < WB_DW / 8; b++) begin
      m[8*b +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchroniser bringing asynchronous pad inputs into the clk domain.
module gpio_sync #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= async_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign sync_out = stage_q[DEPTH-1];

endmodule

// File: rtl/gpio_wb_responder.sv
// Wishbone-classic GPIO bank: output data/direction registers, synchronised
// pad sampling and per-line edge interrupts with write-1-to-clear status.
module gpio_wb_responder
  import gpio_pkg::*;
#(
  parameter int NGPIO      = 32,
  parameter int SYNC_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [WB_AW-1:0] wb_adr_i,
  input  logic [3:0]       wb_sel_i,
  input  logic [WB_DW-1:0] wb_dat_i,
  output logic [WB_DW-1:0] wb_dat_o,
  output logic             wb_ack_o,
  input  logic [NGPIO-1:0] i_gpio,
  output logic [NGPIO-1:0] o_gpio,
  output logic [NGPIO-1:0] en_gpio,
  output logic             irq_o
);

  logic [NGPIO-1:0] s_in;
  logic [NGPIO-1:0] prev_q;
  logic [NGPIO-1:0] data_out_q;
  logic [NGPIO-1:0] dir_q;
  logic [NGPIO-1:0] irq_en_q;
  logic [NGPIO-1:0] irq_stat_q;
  logic [NGPIO-1:0] edge_pol_q;

  logic             req;
  logic             wr_req;
  logic             rd_req;
  gpio_reg_e        reg_idx;
  logic [WB_DW-1:0] lane_bits;
  logic [WB_DW-1:0] rd_data;
  logic [NGPIO-1:0] edge_hit;
  logic [NGPIO-1:0] w1c_clear;

  gpio_sync #(
    .WIDTH (NGPIO),
    .DEPTH (SYNC_DEPTH)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (i_gpio),
    .sync_out (s_in)
  );

  // A request is only taken while no ack is outstanding, so held strobes
  // complete every other cycle.
  assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_req    = req & wb_we_i;
  assign rd_req    = req & ~wb_we_i;
  assign reg_idx   = gpio_reg_e'(wb_adr_i[4:2]);
  assign lane_bits = lane_mask(wb_sel_i);

  function automatic logic [NGPIO-1:0] merge_lanes(input logic [NGPIO-1:0] old_val);
    logic [WB_DW-1:0] merged;
    merged = (WB_DW'(old_val) & ~lane_bits) | (wb_dat_i & lane_bits);
    return NGPIO'(merged);
  endfunction

  always_comb begin
    rd_data = '0;
    case (reg_idx)
      GPIO_DATA_IN:  rd_data = WB_DW'(s_in);
      GPIO_DATA_OUT: rd_data = WB_DW'(data_out_q);
      GPIO_DIR:      rd_data = WB_DW'(dir_q);
      GPIO_IRQ_EN:   rd_data = WB_DW'(irq_en_q);
      GPIO_IRQ_STAT: rd_data = WB_DW'(irq_stat_q);
      GPIO_EDGE_POL: rd_data = WB_DW'(edge_pol_q);
      default:       rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= rd_req ? rd_data : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q <= '0;
      dir_q      <= '0;
      irq_en_q   <= '0;
      edge_pol_q <= '0;
    end else if (wr_req) begin
      case (reg_idx)
        GPIO_DATA_OUT: data_out_q <= merge_lanes(data_out_q);
        GPIO_DIR:      dir_q      <= merge_lanes(dir_q);
        GPIO_IRQ_EN:   irq_en_q   <= merge_lanes(irq_en_q);
        GPIO_EDGE_POL: edge_pol_q <= merge_lanes(edge_pol_q);
        default:       ;
      endcase
    end
  end

  // prev_q tracks the synchronised data, so flipping EDGE_POL alone never
  // fabricates an edge.
  assign edge_hit  = (s_in & ~prev_q & ~edge_pol_q) | (~s_in & prev_q & edge_pol_q);
  assign w1c_clear = (wr_req && reg_idx == GPIO_IRQ_STAT) ? NGPIO'(wb_dat_i & lane_bits) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q     <= '0;
      irq_stat_q <= '0;
    end else begin
      prev_q     <= s_in;
      irq_stat_q <= (irq_stat_q & ~w1c_clear) | edge_hit;
    end
  end

  assign o_gpio  = data_out_q;
  assign en_gpio = dir_q;
  assign irq_o   = |(irq_stat_q & irq_en_q);

endmodule
